// File: rtl/bus_pkg.sv
// bus_pkg: shared bus source codes, op codes, controller states and legality helpers
package bus_pkg;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;
  typedef enum logic [1:0] {OP_MOVE, OP_ALU, OP_MUL, OP_ILL} opT;
  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_OPA, S_OPB, S_WAIT, S_WB_LO, S_WB_HI, S_ERR} stateT;
  function automatic logic srcOk(logic [4:0] s);
    return s <= SRC_CSIGN;
  endfunction
  function automatic logic dstOk(logic [4:0] d);
    return d <= SRC_LO || d == SRC_PC;
  endfunction
endpackage

// File: rtl/dst_decode.sv
// dst_decode: destination code plus enable to one-hot register/HI/LO/PC load enables
module dst_decode
  import bus_pkg::*;
(
  input  logic [4:0]  dst,
  input  logic        en,
  output logic [15:0] regIn,
  output logic        hiIn,
  output logic        loIn,
  output logic        pcIn
);
  assign regIn = (en && !dst[4]) ? 16'd1 << dst[3:0] : '0;
  assign hiIn  = en && dst == SRC_HI;
  assign loIn  = en && dst == SRC_LO;
  assign pcIn  = en && dst == SRC_PC;
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences MOVE/ALU/MUL bus transfers with ALU wait timeout and error pulses
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int ALU_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_src_a,
  input  logic [4:0]  req_src_b,
  input  logic [4:0]  req_dst,
  output logic [4:0]  bus_sel,
  output logic [15:0] reg_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        pc_in,
  output logic        y_in,
  output logic        z_in,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        busy,
  output logic        done,
  output logic        err
);
  stateT state, nextState;
  opT opQ;
  logic [4:0] srcAQ, srcBQ, dstQ, wrDst;
  logic [15:0] waitCnt;
  logic wrEn, legal, timeout;
  assign legal = opT'(req_op) != OP_ILL && srcOk(req_src_a)
              && (opT'(req_op) == OP_MOVE || srcOk(req_src_b))
              && (opT'(req_op) == OP_MUL || dstOk(req_dst));
  assign timeout = waitCnt >= 16'(ALU_TIMEOUT);
  assign req_ready = state == S_IDLE;
  assign busy = !req_ready;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      opQ <= OP_MOVE;
      srcAQ <= '0;
      srcBQ <= '0;
      dstQ <= '0;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (req_valid && req_ready) begin
        opQ <= opT'(req_op);
        srcAQ <= req_src_a;
        srcBQ <= req_src_b;
        dstQ <= req_dst;
      end
      waitCnt <= state == S_OPB ? 16'd1 : state == S_WAIT ? waitCnt + 16'd1 : '0;
    end
  end
  // MUL write-back reuses the decoder by steering the destination to LO then HI
  always_comb begin
    nextState = state;
    bus_sel = '0;
    wrDst = dstQ;
    wrEn = 1'b0;
    y_in = 1'b0;
    z_in = 1'b0;
    alu_start = 1'b0;
    done = 1'b0;
    err = 1'b0;
    case (state)
      S_IDLE:  if (req_valid) nextState = !legal ? S_ERR : opT'(req_op) == OP_MOVE ? S_MOVE : S_OPA;
      S_MOVE: begin
        bus_sel = srcAQ;
        wrEn = 1'b1;
        done = 1'b1;
        nextState = S_IDLE;
      end
      S_OPA: begin
        bus_sel = srcAQ;
        y_in = 1'b1;
        nextState = S_OPB;
      end
      S_OPB: begin
        bus_sel = srcBQ;
        alu_start = 1'b1;
        nextState = S_WAIT;
      end
      S_WAIT: begin
        bus_sel = srcBQ;
        z_in = alu_done;
        err = !alu_done && timeout;
        nextState = alu_done ? S_WB_LO : timeout ? S_IDLE : S_WAIT;
      end
      S_WB_LO: begin
        bus_sel = SRC_ZLO;
        wrEn = 1'b1;
        wrDst = opQ == OP_MUL ? SRC_LO : dstQ;
        done = opQ != OP_MUL;
        nextState = opQ == OP_MUL ? S_WB_HI : S_IDLE;
      end
      S_WB_HI: begin
        bus_sel = SRC_ZHI;
        wrEn = 1'b1;
        wrDst = SRC_HI;
        done = 1'b1;
        nextState = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        nextState = S_IDLE;
      end
    endcase
  end
  dst_decode uDec (
    .dst(wrDst),
    .en(wrEn),
    .regIn(reg_in),
    .hiIn(hi_in),
    .loIn(lo_in),
    .pcIn(pc_in)
  );
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: table, hand-written and random requests checked cycle by cycle against a trace model
module tb_bus_xfer_ctrl;
  localparam int TO = 4;
  logic clock = 1'b0, resetn = 1'b0, req_valid = 1'b0, alu_done = 1'b0;
  logic [1:0] req_op = '0;
  logic [4:0] req_src_a = '0, req_src_b = '0, req_dst = '0;
  logic req_ready, hi_in, lo_in, pc_in, y_in, z_in, alu_start, busy, done, err;
  logic [4:0] bus_sel;
  logic [15:0] reg_in;
  typedef struct packed {
    logic [4:0] sel;
    logic [15:0] regs;
    logic hi, lo, pc, y, z, start, done, err, busy, ready;
  } outs_t;
  typedef struct {
    logic [1:0] op;
    logic [4:0] a, b, dst;
    int delay, expLen;
    bit expDone, expErr;
  } rec_t;
  int nCmp = 0, nFail = 0;
  outs_t expQ[$];
  always #5 clock = ~clock;
  bus_xfer_ctrl #(.ALU_TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
    .bus_sel(bus_sel), .reg_in(reg_in), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in),
    .y_in(y_in), .z_in(z_in), .alu_start(alu_start), .alu_done(alu_done),
    .busy(busy), .done(done), .err(err)
  );
  function automatic outs_t snap();
    return {bus_sel, reg_in, hi_in, lo_in, pc_in, y_in, z_in, alu_start, done, err, busy, req_ready};
  endfunction
  function automatic outs_t idleS();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction
  function automatic outs_t mk(logic [4:0] sel);
    outs_t o = '0;
    o.sel = sel;
    o.busy = 1'b1;
    return o;
  endfunction
  function automatic outs_t withLoad(outs_t i, logic [4:0] d);
    outs_t o = i;
    if (d < 5'd16) o.regs[d[3:0]] = 1'b1;
    else if (d == 5'd16) o.hi = 1'b1;
    else if (d == 5'd17) o.lo = 1'b1;
    else if (d == 5'd20) o.pc = 1'b1;
    return o;
  endfunction
  function automatic bit isLegal(rec_t r);
    return r.op != 2'd3 && r.a < 5'd24 && (r.op == 2'd0 || r.b < 5'd24)
        && (r.op == 2'd2 || r.dst < 5'd18 || r.dst == 5'd20);
  endfunction
  // Expected per-cycle outputs from acceptance+1 until the controller is idle again
  function automatic void buildExp(rec_t r);
    outs_t o;
    int k;
    expQ.delete();
    if (!isLegal(r)) begin
      o = mk(5'd0);
      o.err = 1'b1;
      expQ.push_back(o);
      return;
    end
    if (r.op == 2'd0) begin
      o = withLoad(mk(r.a), r.dst);
      o.done = 1'b1;
      expQ.push_back(o);
      return;
    end
    o = mk(r.a);
    o.y = 1'b1;
    expQ.push_back(o);
    o = mk(r.b);
    o.start = 1'b1;
    expQ.push_back(o);
    k = r.delay < TO ? r.delay : TO;
    for (int w = 1; w <= k; w++) begin
      o = mk(r.b);
      o.z = w == r.delay;
      o.err = w == TO && r.delay > TO;
      expQ.push_back(o);
    end
    if (r.delay > TO) return;
    if (r.op == 2'd1) begin
      o = withLoad(mk(5'd19), r.dst);
      o.done = 1'b1;
      expQ.push_back(o);
    end else begin
      o = mk(5'd19);
      o.lo = 1'b1;
      expQ.push_back(o);
      o = mk(5'd18);
      o.hi = 1'b1;
      o.done = 1'b1;
      expQ.push_back(o);
    end
  endfunction
  task automatic check(string name, outs_t g, outs_t e);
    nCmp++;
    if (g !== e) begin
      nFail++;
      $display("FAIL %s: got sel=%0d reg=%h flags(hi,lo,pc,y,z,start,done,err,busy,ready)=%b want sel=%0d reg=%h flags=%b",
               name, g.sel, g.regs, g[9:0], e.sel, e.regs, e[9:0]);
    end
  endtask
  task automatic checkInt(string name, int g, int e);
    nCmp++;
    if (g != e) begin
      nFail++;
      $display("FAIL %s: got %0d want %0d", name, g, e);
    end
  endtask
  task automatic drive(rec_t r);
    req_op = r.op;
    req_src_a = r.a;
    req_src_b = r.b;
    req_dst = r.dst;
  endtask
  task automatic runReq(rec_t r, bit hold, rec_t nxt, output int len, output int nDone, output int nErr);
    outs_t g;
    int n, k;
    bit inWait;
    buildExp(r);
    n = expQ.size();
    k = r.delay < TO ? r.delay : TO;
    len = 0;
    nDone = 0;
    nErr = 0;
    @(negedge clock);
    req_valid = 1'b1;
    drive(r);
    alu_done = 1'($urandom);
    #1 check("accept", snap(), idleS());
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (hold) begin
        req_valid = 1'b1;
        drive(nxt);
      end else begin
        req_valid = 1'($urandom);
        req_op = 2'($urandom);
        req_src_a = 5'($urandom);
        req_src_b = 5'($urandom);
        req_dst = 5'($urandom);
      end
      inWait = (r.op == 2'd1 || r.op == 2'd2) && n > 1 && i >= 3 && i < 3 + k;
      alu_done = inWait ? i == 2 + r.delay : 1'($urandom);
      #1 g = snap();
      check($sformatf("op%0d cyc%0d", r.op, i), g, expQ[i-1]);
      len += int'(g.busy);
      nDone += int'(g.done);
      nErr += int'(g.err);
    end
  endtask
  function automatic rec_t randRec();
    rec_t r;
    r.op = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
    r.a = ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 24);
    r.b = ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 24);
    r.dst = 5'($urandom);
    r.delay = 1 + int'($urandom % 6);
    r.expLen = 0;
    r.expDone = 1'b0;
    r.expErr = 1'b0;
    return r;
  endfunction
  initial begin
    rec_t tbl[15];
    rec_t cur, nxt, mv, alu;
    int len, nd, ne;
    tbl[0]  = '{2'd0, 5'd20, 5'd0,  5'd5,  1,  1, 1'b1, 1'b0};
    tbl[1]  = '{2'd1, 5'd3,  5'd4,  5'd7,  2,  5, 1'b1, 1'b0};
    tbl[2]  = '{2'd2, 5'd1,  5'd2,  5'd0,  2,  6, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 5'd3,  5'd4,  5'd7,  99, 6, 1'b0, 1'b1};
    tbl[4]  = '{2'd1, 5'd3,  5'd4,  5'd7,  4,  7, 1'b1, 1'b0};
    tbl[5]  = '{2'd3, 5'd1,  5'd1,  5'd1,  1,  1, 1'b0, 1'b1};
    tbl[6]  = '{2'd0, 5'd25, 5'd0,  5'd2,  1,  1, 1'b0, 1'b1};
    tbl[7]  = '{2'd1, 5'd3,  5'd4,  5'd18, 2,  1, 1'b0, 1'b1};
    tbl[8]  = '{2'd2, 5'd5,  5'd6,  5'd30, 1,  5, 1'b1, 1'b0};
    tbl[9]  = '{2'd1, 5'd5,  5'd24, 5'd3,  1,  1, 1'b0, 1'b1};
    tbl[10] = '{2'd0, 5'd22, 5'd31, 5'd20, 1,  1, 1'b1, 1'b0};
    tbl[11] = '{2'd0, 5'd0,  5'd0,  5'd16, 1,  1, 1'b1, 1'b0};
    tbl[12] = '{2'd0, 5'd1,  5'd0,  5'd19, 1,  1, 1'b0, 1'b1};
    tbl[13] = '{2'd1, 5'd23, 5'd0,  5'd17, 1,  4, 1'b1, 1'b0};
    tbl[14] = '{2'd2, 5'd1,  5'd2,  5'd0,  5,  6, 1'b0, 1'b1};
    repeat (2) @(negedge clock);
    check("reset", snap(), idleS());
    resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      runReq(tbl[i], 1'b0, tbl[i], len, nd, ne);
      checkInt($sformatf("tbl%0d len", i), len, tbl[i].expLen);
      checkInt($sformatf("tbl%0d done", i), nd, int'(tbl[i].expDone));
      checkInt($sformatf("tbl%0d err", i), ne, int'(tbl[i].expErr));
    end
    mv = '{2'd0, 5'd21, 5'd0, 5'd9, 1, 1, 1'b1, 1'b0};
    alu = tbl[1];
    runReq(alu, 1'b1, mv, len, nd, ne);
    runReq(mv, 1'b0, mv, len, nd, ne);
    checkInt("held move done", nd, 1);
    @(negedge clock);
    req_valid = 1'b1;
    drive(alu);
    alu_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      req_valid = 1'b0;
    end
    #1 check("pre-reset wait", snap(), mk(5'd4));
    #1 resetn = 1'b0;
    #1 check("reset in wait", snap(), idleS());
    @(negedge clock);
    check("reset held", snap(), idleS());
    resetn = 1'b1;
    runReq(mv, 1'b0, mv, len, nd, ne);
    checkInt("post-reset move done", nd, 1);
    cur = randRec();
    for (int i = 0; i < 300; i++) begin
      nxt = randRec();
      runReq(cur, $urandom % 4 == 0, nxt, len, nd, ne);
      cur = nxt;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
